// File: rtl/bin14_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin14_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-add-3 (double dabble).
//   Converts one input bit per clock under a start/busy/done handshake.
//   The result is written to bcd in a single step and held until the next
//   conversion finishes.
//
// Parameters
//   WIDTH   binary input width in bits (>= 1)
//   DIGITS  number of BCD output digits (10^DIGITS > 2^WIDTH-1)
//
// Ports
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous reset, active-high
//   start  in   1          conversion request, sampled only while busy=0
//   bin    in   WIDTH      unsigned value, captured on the accepted start
//   busy   out  1          high while a conversion is in flight (SHIFT/DONE)
//   done   out  1          single-cycle pulse: bcd holds a fresh result
//   bcd    out  4*DIGITS   packed BCD, digit 0 (units) in bcd[3:0]
//   ovf    out  1          saturation flag
//
// Build option
//   BCD_SAT_9999_EN  when defined, results above 9999 saturate to 0x..09999
//                    and set ovf; when undefined ovf is tied low and bcd is
//                    always the exact value. Timing is the same either way.
// -----------------------------------------------------------------------------
module bin14_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CAT_W = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [WIDTH-1:0]    r_bin;
  logic [BCD_W-1:0]    r_dig;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic [BCD_W-1:0]    r_bcd;

  logic [BCD_W-1:0]    w_adj;
  logic [CAT_W-1:0]    w_shifted;
  logic                w_last;
  logic [BCD_W-1:0]    w_bcd_result;

  // Add-3 correction on each scratch digit. 4-bit add, carry discarded:
  // a digit in 5..9 becomes 8..12, which still fits in four bits.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_dig[4*gi +: 4] >= 4'd5) ?
                                (r_dig[4*gi +: 4] + 4'd3) :
                                r_dig[4*gi +: 4];
    end
  endgenerate

  // Digits and remaining binary bits move left together as one vector.
  assign w_shifted = {w_adj, r_bin} << 1;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_dig  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      // done is registered so it lines up with the freshly loaded bcd.
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin <= bin;
            r_dig <= '0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_dig <= w_shifted[CAT_W-1:WIDTH];
          r_bin <= w_shifted[WIDTH-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_bcd <= w_bcd_result;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BCD_SAT_9999_EN
  logic w_over;
  logic r_ovf;

  // Anything in digit 4 or above means the value exceeds 9999.
  generate
    if (DIGITS > 4) begin : g_over
      assign w_over = |r_dig[BCD_W-1:16];
    end else begin : g_no_over
      assign w_over = 1'b0;
    end
  endgenerate

  assign w_bcd_result = w_over ? BCD_W'(16'h9999) : r_dig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ovf <= w_over;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_bcd_result = r_dig;
  assign ovf          = 1'b0;
`endif

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin14_to_bcd_seq.sv
// Testbench for bin14_to_bcd_seq: directed scenarios plus randomized
// back-to-back streaming, checked against a decimal-arithmetic reference.
module tb_bin14_to_bcd_seq;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 5;
`ifdef BCD_SAT_9999_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              busy;
  logic              done;
  logic [19:0]       bcd;
  logic              ovf;

  int checks   = 0;
  int failures = 0;

  bin14_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] model_bcd(input int v);
    int x;
    logic [19:0] r;
    x = v;
    r = '0;
    if (SAT && x > 9999) x = 9999;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    return SAT && (v > 9999);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion from idle and wait (bounded) for done.
  task automatic do_conv(input int v, output logic [19:0] b, output logic o,
                         output int lat, output int bcnt);
    bin   = WIDTH'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
    lat   = -1;
    b     = 'x;
    o     = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        b   = bcd;
        o   = ovf;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; bin = 14'd1234;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=00000", bcd); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_zero;
    logic [19:0] b; logic o; int lat, bcnt;
    do_conv(0, b, o, lat, bcnt);
    checks++; if (lat != 15) begin failures++; $display("FAIL zero_latency got=%0d exp=15", lat); end
    checks++; if (bcnt != 15) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=15", bcnt); end
    checks++; if (b !== 20'h0) begin failures++; $display("FAIL zero_bcd got=%h exp=00000", b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_at_done got=%b exp=0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL zero_bcd_hold got=%h exp=00000", bcd); end
    $display("test_zero bin=0 bcd=%h lat=%0d busy=%0d", b, lat, bcnt);
  endtask

  task automatic test_value(input int v);
    logic [19:0] b; logic o; int lat, bcnt;
    do_conv(v, b, o, lat, bcnt);
    checks++; if (lat != 15) begin failures++; $display("FAIL value_latency v=%0d got=%0d exp=15", v, lat); end
    checks++; if (b !== model_bcd(v)) begin failures++; $display("FAIL value_bcd v=%0d got=%h exp=%h", v, b, model_bcd(v)); end
    checks++; if (o !== model_ovf(v)) begin failures++; $display("FAIL value_ovf v=%0d got=%b exp=%b", v, o, model_ovf(v)); end
    tick();
    checks++; if (bcd !== model_bcd(v)) begin failures++; $display("FAIL value_hold v=%0d got=%h exp=%h", v, bcd, model_bcd(v)); end
    $display("test_value bin=%0d bcd=%h ovf=%b", v, b, o);
  endtask

  task automatic test_busy_ignore;
    int ndone; logic [19:0] b;
    ndone = 0; b = 'x;
    bin = 14'd1234; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    bin = 14'd42; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) begin ndone++; b = bcd; end
    end
    checks++; if (ndone != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (b !== 20'h01234) begin failures++; $display("FAIL ignore_bcd got=%h exp=01234", b); end
    $display("test_busy_ignore dones=%0d bcd=%h", ndone, b);
  endtask

  task automatic test_rst_abort;
    int ndone; logic [19:0] b; logic o; int lat, bcnt;
    ndone = 0;
    bin = 14'd4321; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL abort_bcd got=%h exp=00000", bcd); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    do_conv(7, b, o, lat, bcnt);
    checks++; if (b !== 20'h00007) begin failures++; $display("FAIL abort_after_bcd got=%h exp=00007", b); end
    $display("test_rst_abort post-reset bcd=%h", b);
  endtask

  task automatic test_back_to_back;
    int exp_q[$]; int idx, got, last, v;
    bin = 14'd100; exp_q.push_back(100); idx = 1; got = 0; last = -1;
    start = 1'b1;
    for (int t = 0; t < 3 * 16 + 40 && got < 3; t++) begin
      tick();
      if (done) begin
        v = exp_q.pop_front();
        checks++; if (bcd !== model_bcd(v)) begin failures++; $display("FAIL b2b_bcd v=%0d got=%h exp=%h", v, bcd, model_bcd(v)); end
        if (got > 0) begin
          checks++; if (t - last != 16) begin failures++; $display("FAIL b2b_interval got=%0d exp=16", t - last); end
        end
        $display("test_back_to_back bin=%0d bcd=%h t=%0d", v, bcd, t);
        last = t; got++;
        if (idx < 3) begin bin = WIDTH'(100 + idx); exp_q.push_back(100 + idx); idx++; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL b2b_timeout got=%0d exp=3", got); end
    repeat (20) tick();
  endtask

  task automatic test_random(input int n);
    int vals[]; int exp_q[$]; int idx, got, last, v;
    vals = new[n];
    for (int i = 0; i < n; i++) begin
      case (i % 8)
        0: vals[i] = 9999 + int'($urandom_range(0, 2));
        1: vals[i] = int'($urandom_range(16380, 16383));
        2: vals[i] = int'($urandom_range(0, 20));
        default: vals[i] = int'($urandom_range(0, 16383));
      endcase
    end
    bin = WIDTH'(vals[0]); exp_q.push_back(vals[0]); idx = 1; got = 0; last = -1;
    start = 1'b1;
    for (int t = 0; t < n * 16 + 40 && got < n; t++) begin
      tick();
      if (done) begin
        v = exp_q.pop_front();
        checks++; if (bcd !== model_bcd(v)) begin failures++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd, model_bcd(v)); end
        checks++; if (ovf !== model_ovf(v)) begin failures++; $display("FAIL rand_ovf v=%0d got=%b exp=%b", v, ovf, model_ovf(v)); end
        checks++; if (t - last != ((got == 0) ? 16 : 16) && got > 0) begin failures++; $display("FAIL rand_interval got=%0d exp=16", t - last); end
        $display("test_random bin=%0d bcd=%h ovf=%b", v, bcd, ovf);
        last = t; got++;
        if (idx < n) begin bin = WIDTH'(vals[idx]); exp_q.push_back(vals[idx]); idx++; end
        else start = 1'b0;
      end else if (busy) begin
        // Scribble on bin mid-conversion; it must not disturb the result.
        bin = WIDTH'($urandom);
      end
    end
    start = 1'b0;
    checks++; if (got != n) begin failures++; $display("FAIL rand_timeout got=%0d exp=%0d", got, n); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    test_reset();
    test_zero();
    test_value(9999);
    test_value(16383);
    test_value(10000);
    test_busy_ignore();
    test_rst_abort();
    test_back_to_back();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
